// File: rtl/onehot_ring_pkg.sv
// Shared definitions for the one-hot ring counter: direction codes,
// per-edge action selector and width helpers.
package onehot_ring_pkg;

    localparam int unsigned MAXW = 32;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Decision taken at each clock edge, listed in priority order.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_RECOVER,
        ACT_REJECT,
        ACT_LOAD,
        ACT_STEP,
        ACT_HOLD
    } ring_act_e;

    // max(1, ceil(log2(n)))
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic is_onehot(input logic [MAXW-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder: each index bit is the OR of the one-hot
// positions whose binary index has that bit set.
module onehot_to_bin
    import onehot_ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic [WIDTH-1:0] i_onehot,
    output logic [IDXW-1:0]  o_idx
);

    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_ring_counter.sv
// Bidirectional one-hot ring counter with synchronous load, wrap pulse and
// self-recovery from non-one-hot states. y is the only state held.
module onehot_ring_counter
    import onehot_ring_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int RESET_IDX = 0,
    localparam int IDXW      = idx_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt,
    input  logic              dir,
    input  logic              load,
    input  logic [IDXW-1:0]   load_idx,
    output logic [WIDTH-1:0]  y,
    output logic [IDXW-1:0]   idx,
    output logic              wrap,
    output logic              err
);

    localparam logic [WIDTH-1:0] RESET_VEC = WIDTH'(1) << RESET_IDX;
    localparam logic [31:0]      WIDTH_U   = 32'(WIDTH);

    logic [WIDTH-1:0] r_y;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_rot_up;
    logic [WIDTH-1:0] w_rot_dn;
    logic [WIDTH-1:0] w_load_vec;
    logic             w_wrap_hit;
    logic             w_legal;
    logic             w_load_ok;
    logic [IDXW-1:0]  w_idx;
    ring_act_e        w_act;

    assign w_rot_up   = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
    assign w_rot_dn   = {r_y[0], r_y[WIDTH-1:1]};
    assign w_load_vec = WIDTH'(1) << load_idx;
    assign w_wrap_hit = (dir == DIR_UP) ? r_y[WIDTH-1] : r_y[0];
    assign w_legal    = is_onehot(MAXW'(r_y));
    assign w_load_ok  = (32'(load_idx) < WIDTH_U);

    // An illegal state outranks load/cnt so recovery is never skipped.
    always_comb begin
        w_act = ACT_HOLD;
        if (rst) begin
            w_act = ACT_RESET;
        end else if (!w_legal) begin
            w_act = ACT_RECOVER;
        end else if (load) begin
            w_act = w_load_ok ? ACT_LOAD : ACT_REJECT;
        end else if (cnt) begin
            w_act = ACT_STEP;
        end
    end

    always_ff @(posedge clk) begin
        r_wrap <= 1'b0;
        r_err  <= 1'b0;
        case (w_act)
            ACT_RESET: begin
                r_y <= RESET_VEC;
            end
            ACT_RECOVER: begin
                r_y   <= RESET_VEC;
                r_err <= 1'b1;
            end
            ACT_REJECT: begin
                r_err <= 1'b1;
            end
            ACT_LOAD: begin
                r_y <= w_load_vec;
            end
            ACT_STEP: begin
                r_y    <= (dir == DIR_UP) ? w_rot_up : w_rot_dn;
                r_wrap <= w_wrap_hit;
            end
            default: begin
                r_y <= r_y;
            end
        endcase
    end

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .i_onehot (r_y),
        .o_idx    (w_idx)
    );

    assign y    = r_y;
    assign idx  = w_idx;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule

// File: tb/tb_onehot_ring_counter.sv
// Self-checking bench: three counter instances (4, 5 and 8 wide) driven in
// lock-step and compared against a position-arithmetic reference model.
module tb_onehot_ring_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cnt = 1'b0;
    logic dir = 1'b0;
    logic load = 1'b0;
    logic [1:0] li4 = '0;
    logic [2:0] li5 = '0;
    logic [2:0] li8 = '0;

    logic [3:0] y4;
    logic [1:0] idx4;
    logic       wrap4, err4;
    logic [4:0] y5;
    logic [2:0] idx5;
    logic       wrap5, err5;
    logic [7:0] y8;
    logic [2:0] idx8;
    logic       wrap8, err8;

    int total = 0;
    int bad   = 0;

    // Reference model: hot position per instance, plus expected pulses.
    int mw[3] = '{4, 5, 8};
    int mr[3] = '{0, 0, 3};
    int mpos[3];
    bit mwrap[3];
    bit merr[3];

    logic [31:0] ay[3];
    logic [31:0] ai[3];
    logic        aw[3];
    logic        ae[3];

    always #5 clk = ~clk;

    onehot_ring_counter #(.WIDTH(4), .RESET_IDX(0)) dut4 (
        .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .load(load), .load_idx(li4),
        .y(y4), .idx(idx4), .wrap(wrap4), .err(err4)
    );
    onehot_ring_counter #(.WIDTH(5), .RESET_IDX(0)) dut5 (
        .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .load(load), .load_idx(li5),
        .y(y5), .idx(idx5), .wrap(wrap5), .err(err5)
    );
    onehot_ring_counter #(.WIDTH(8), .RESET_IDX(3)) dut8 (
        .clk(clk), .rst(rst), .cnt(cnt), .dir(dir), .load(load), .load_idx(li8),
        .y(y8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    assign ay[0] = 32'(y4);
    assign ay[1] = 32'(y5);
    assign ay[2] = 32'(y8);
    assign ai[0] = 32'(idx4);
    assign ai[1] = 32'(idx5);
    assign ai[2] = 32'(idx8);
    assign aw[0] = wrap4;
    assign aw[1] = wrap5;
    assign aw[2] = wrap8;
    assign ae[0] = err4;
    assign ae[1] = err5;
    assign ae[2] = err8;

    // One clock edge: advance the model with the sampled inputs, then settle.
    task automatic step();
        int li_v[3];
        @(posedge clk);
        li_v[0] = int'(li4);
        li_v[1] = int'(li5);
        li_v[2] = int'(li8);
        for (int k = 0; k < 3; k++) begin
            mwrap[k] = 1'b0;
            merr[k]  = 1'b0;
            if (rst) begin
                mpos[k] = mr[k];
            end else if (load) begin
                if (li_v[k] < mw[k]) mpos[k] = li_v[k];
                else merr[k] = 1'b1;
            end else if (cnt) begin
                if (!dir) begin
                    mwrap[k] = (mpos[k] == mw[k] - 1);
                    mpos[k]  = (mpos[k] + 1) % mw[k];
                end else begin
                    mwrap[k] = (mpos[k] == 0);
                    mpos[k]  = (mpos[k] + mw[k] - 1) % mw[k];
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt = 1'b0; load = 1'b0; dir = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (ay[k] !== (32'd1 << mr[k])) begin
                    bad++; $display("FAIL reset_y inst%0d cyc%0d: got %0h want %0h", k, c, ay[k], 32'd1 << mr[k]);
                end
                total++;
                if (ai[k] !== 32'(mr[k]) || aw[k] !== 1'b0 || ae[k] !== 1'b0) begin
                    bad++; $display("FAIL reset_flags inst%0d cyc%0d: idx=%0d wrap=%b err=%b want idx=%0d wrap=0 err=0", k, c, ai[k], aw[k], ae[k], mr[k]);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_y[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst = 1'b1; step(); rst = 1'b0;
        cnt = 1'b1; dir = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (y4 !== exp_y[c] || wrap4 !== (c == 3)) begin
                bad++; $display("FAIL up_wrap cyc%0d: y=%b wrap=%b want y=%b wrap=%b", c, y4, wrap4, exp_y[c], (c == 3));
            end
        end
        cnt = 1'b0;
    endtask

    task automatic test_down_wrap();
        rst = 1'b1; step(); rst = 1'b0;
        cnt = 1'b1; dir = 1'b1;
        step();
        total++;
        if (y4 !== 4'b1000 || wrap4 !== 1'b1 || idx4 !== 2'd3) begin
            bad++; $display("FAIL down_wrap1: y=%b idx=%0d wrap=%b want y=1000 idx=3 wrap=1", y4, idx4, wrap4);
        end
        step();
        total++;
        if (y4 !== 4'b0100 || wrap4 !== 1'b0) begin
            bad++; $display("FAIL down_wrap2: y=%b wrap=%b want y=0100 wrap=0", y4, wrap4);
        end
        total++;
        if (y8 !== 8'b0000_0010 || wrap8 !== 1'b0) begin
            bad++; $display("FAIL down_w8: y=%b wrap=%b want y=00000010 wrap=0", y8, wrap8);
        end
        cnt = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load();
        logic [4:0] y5_before;
        rst = 1'b1; step(); rst = 1'b0;
        load = 1'b1; cnt = 1'b1; li4 = 2'd2; li5 = 3'd2; li8 = 3'd2;
        step();
        total++;
        if (y4 !== 4'b0100 || idx4 !== 2'd2 || wrap4 !== 1'b0 || err4 !== 1'b0) begin
            bad++; $display("FAIL load_legal: y=%b idx=%0d wrap=%b err=%b want y=0100 idx=2 wrap=0 err=0", y4, idx4, wrap4, err4);
        end
        y5_before = y5;
        li5 = 3'd6; li4 = 2'd1; li8 = 3'd7;
        step();
        total++;
        if (y5 !== y5_before || err5 !== 1'b1 || wrap5 !== 1'b0) begin
            bad++; $display("FAIL load_reject: y=%b err=%b wrap=%b want y=%b err=1 wrap=0", y5, err5, wrap5, y5_before);
        end
        total++;
        if (y8 !== 8'b1000_0000 || idx8 !== 3'd7 || err8 !== 1'b0) begin
            bad++; $display("FAIL load_w8: y=%b idx=%0d err=%b want y=10000000 idx=7 err=0", y8, idx8, err8);
        end
        load = 1'b0; cnt = 1'b0;
        step();
        total++;
        if (err5 !== 1'b0 || y5 !== y5_before) begin
            bad++; $display("FAIL reject_pulse: err=%b y=%b want err=0 y=%b", err5, y5, y5_before);
        end
    endtask

    task automatic test_simultaneous();
        load = 1'b1; li4 = 2'd2; step(); load = 1'b0;
        rst = 1'b1; load = 1'b1; cnt = 1'b1; li4 = 2'd3; li5 = 3'd3; li8 = 3'd3;
        step();
        total++;
        if (y4 !== 4'b0001 || idx4 !== 2'd0 || wrap4 !== 1'b0 || err4 !== 1'b0) begin
            bad++; $display("FAIL simultaneous: y=%b idx=%0d wrap=%b err=%b want y=0001 idx=0 wrap=0 err=0", y4, idx4, wrap4, err4);
        end
        total++;
        if (y8 !== 8'b0000_1000 || wrap8 !== 1'b0 || err8 !== 1'b0) begin
            bad++; $display("FAIL simultaneous_w8: y=%b wrap=%b err=%b want y=00001000 wrap=0 err=0", y8, wrap8, err8);
        end
        rst = 1'b0; load = 1'b0; cnt = 1'b0;
    endtask

    task automatic test_illegal();
        #2;
        force dut8.r_y = 8'b0000_0101;
        #1;
        total++;
        if (y8 !== 8'b0000_0101) begin
            bad++; $display("FAIL illegal_setup: y=%b want y=00000101", y8);
        end
        release dut8.r_y;
        load = 1'b1; cnt = 1'b1; li4 = 2'd1; li5 = 3'd1; li8 = 3'd6;
        step();
        mpos[2] = 3; merr[2] = 1'b1; mwrap[2] = 1'b0;
        total++;
        if (y8 !== 8'b0000_1000 || idx8 !== 3'd3 || err8 !== 1'b1 || wrap8 !== 1'b0) begin
            bad++; $display("FAIL illegal_recover: y=%b idx=%0d err=%b wrap=%b want y=00001000 idx=3 err=1 wrap=0", y8, idx8, err8, wrap8);
        end
        load = 1'b0; cnt = 1'b0;
        step();
        total++;
        if (y8 !== 8'b0000_1000 || err8 !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse: y=%b err=%b want y=00001000 err=0", y8, err8);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 3) == 0);
            cnt  = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom);
            li4  = 2'($urandom);
            li5  = 3'($urandom);
            li8  = 3'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (ay[k] !== (32'd1 << mpos[k]) || ai[k] !== 32'(mpos[k]) || aw[k] !== mwrap[k] || ae[k] !== merr[k]) begin
                    bad++;
                    $display("FAIL random inst%0d cyc%0d: y=%0h idx=%0d wrap=%b err=%b want y=%0h idx=%0d wrap=%b err=%b",
                             k, c, ay[k], ai[k], aw[k], ae[k], 32'd1 << mpos[k], mpos[k], mwrap[k], merr[k]);
                end
            end
        end
        rst = 1'b0; load = 1'b0; cnt = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_simultaneous();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_ring_counter.md
ONEHOT_RING_COUNTER -- requirements
Module: onehot_ring_counter

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the number of one-hot states; legal range 2..32.
REQ-002 Parameter RESET_IDX SHALL default to 0 and set the bit position that is hot after reset; legal range 0..WIDTH-1.
REQ-003 Derived constant IDXW SHALL equal max(1, ceil(log2(WIDTH))).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cnt  input  1  step enable; the counter advances one position per clock while high.
REQ-007 dir  input  1  step direction; 0 = up (bit i to bit i+1), 1 = down (bit i to bit i-1).
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_idx  input  IDXW  bit position to make hot on load.
REQ-010 y  output  WIDTH  one-hot count value, registered.
REQ-011 idx  output  IDXW  binary index of the hot bit in y, combinationally derived from y.
REQ-012 wrap  output  1  registered one-cycle pulse marking a wrap-around step.
REQ-013 err  output  1  registered one-cycle pulse marking a rejected load or a recovered illegal state.

Function
REQ-014 Per-edge priority SHALL be: rst, then load, then cnt, then hold.
REQ-015 With cnt=1, dir=0 and y[WIDTH-1]=1, y SHALL become bit 0 hot and wrap SHALL be 1 for exactly the next cycle.
REQ-016 With cnt=1, dir=1 and y[0]=1, y SHALL become bit WIDTH-1 hot and wrap SHALL be 1 for exactly the next cycle.
REQ-017 On any non-wrapping step, y SHALL rotate by one position in the direction given by dir, and wrap SHALL be 0.
REQ-018 With cnt=0 and load=0, y SHALL hold its value, and wrap and err SHALL be 0.
REQ-019 Latency: y, idx and wrap SHALL reflect a step or load on the clock edge that samples it (1 cycle).
REQ-020 load=1 with load_idx<WIDTH SHALL set y to exactly that bit hot, regardless of cnt; wrap SHALL be 0.
REQ-021 load=1 with load_idx>=WIDTH SHALL leave y unchanged, ignore cnt for that cycle, and pulse err for one cycle.
REQ-022 A change of dir SHALL take effect on the same edge at which it is sampled; there is no turnaround penalty.
REQ-023 If y is ever not one-hot (zero bits or multiple bits set), the next edge without rst SHALL force y to RESET_IDX hot and pulse err; load and cnt SHALL be ignored on that edge.
REQ-024 idx SHALL equal the position of the hot bit whenever y is one-hot; idx is don't-care otherwise.

Reset
REQ-025 While rst=1 at a clock edge, the following SHALL hold: y = bit RESET_IDX hot (WIDTH=4, RESET_IDX=0 gives 0001), idx = RESET_IDX, wrap = 0, err = 0.
REQ-026 rst SHALL override load and cnt on the same edge.
REQ-027 rst asserted mid-count SHALL take effect on the next edge with no residual wrap or err pulse.
REQ-028 There SHALL be no asynchronous reset path.

Structure
REQ-029 A shared package onehot_ring_pkg SHALL hold:
- the direction constants DIR_UP = 0 and DIR_DOWN = 1;
- a clog2-style function used to derive IDXW.
REQ-030 The one-hot-to-binary encoder SHALL be a separate sub-module, onehot_to_bin, parametrised by WIDTH.
REQ-031 Next-state logic and output registers SHALL reside in onehot_ring_counter, with no internal binary state held separately from y.

Verification
REQ-032 Reset and hold (WIDTH=4): rst=1 for 1 cycle, then cnt=0 for 3 cycles -> y=0001, idx=0, wrap=0 throughout.
REQ-033 Up wrap (WIDTH=4): cnt=1, dir=0 for 5 cycles from reset -> y steps 0010, 0100, 1000, 0001, 0010, with wrap=1 only in the cycle y=0001.
REQ-034 Down wrap (WIDTH=4): cnt=1, dir=1 from reset -> y=1000 with wrap=1, then 0100 with wrap=0.
REQ-035 Load (WIDTH=4):
- load=1, load_idx=2, cnt=1 -> y=0100, idx=2.
- then load=1, load_idx=5 (IDXW=2 truncates 5 to 1; use WIDTH=5 with load_idx=6 to exercise this case) -> y unchanged, err pulses for 1 cycle.
REQ-036 Simultaneous events: rst=1, load=1, load_idx=3, cnt=1 on the same edge -> y=RESET_IDX hot, no wrap, no err.
REQ-037 Illegal state (WIDTH=8, RESET_IDX=3): force y to 8'b0000_0101 -> next edge gives y=0000_1000 and err=1 for one cycle.
